// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants and types for the instruction/data memory arbiter
package mem_arbiter_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    // Instruction fetches always read a full word
    localparam logic [3:0] FETCH_MASK = 4'b1111;

    // Latched copy of the granted request; memory outputs are driven only from this
    typedef struct packed {
        logic [29:0] word_addr;
        logic        ren;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_RESET = '0;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single memory port
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_imem_req/addr                   fetch request, held until o_imem_ready
//   o_imem_ready/rdata                one-cycle fetch completion with instruction word
//   i_dmem_ren/wen/addr/wdata/mask    data request, held until o_dmem_ready
//   o_dmem_ready/rdata                one-cycle data completion (rdata for loads)
//   o_mem_*                           unified memory request, registered
//   i_mem_ready/rdata                 memory completion pulse with read data
//   o_conflict_cnt                    saturating count of cycles a pending requester lost
import mem_arbiter_pkg::*;

module mem_arbiter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_ready,
    output logic [31:0] o_imem_rdata,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic [31:0] o_dmem_rdata,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic [15:0] o_conflict_cnt
);

    logic [1:0]  state_q, state_d;
    logic        last_d_q, last_d_d;      // 1: last grant went to dmem
    logic        reentry_q, reentry_d;    // first IDLE cycle after an access: no grant
    mem_req_t    req_q, req_d;
    logic [15:0] cnt_q, cnt_d;

    logic        imem_pend;
    logic        dmem_pend;
    logic        conflict;
    logic        imem_ready;
    logic        dmem_ready;

    // Memory is word addressed; the byte offset bits are intentionally dropped
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{i_imem_addr[1:0], i_dmem_addr[1:0]};

    assign imem_pend = i_imem_req;
    assign dmem_pend = i_dmem_ren | i_dmem_wen;

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        reentry_d  = 1'b0;
        req_d      = req_q;
        conflict   = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                conflict = imem_pend & dmem_pend;
                if (!reentry_q) begin
                    // On a tie the requester not served last wins
                    if (dmem_pend && (!imem_pend || !last_d_q)) begin
                        state_d         = ST_BUSY_D;
                        last_d_d        = 1'b1;
                        req_d.word_addr = i_dmem_addr[31:2];
                        req_d.wen       = i_dmem_wen;
                        req_d.ren       = i_dmem_ren & ~i_dmem_wen;
                        req_d.wdata     = i_dmem_wdata;
                        req_d.mask      = i_dmem_mask;
                    end else if (imem_pend) begin
                        state_d         = ST_BUSY_I;
                        last_d_d        = 1'b0;
                        req_d.word_addr = i_imem_addr[31:2];
                        req_d.wen       = 1'b0;
                        req_d.ren       = 1'b1;
                        req_d.wdata     = 32'h0;
                        req_d.mask      = FETCH_MASK;
                    end
                end
            end
            ST_BUSY_I: begin
                conflict = dmem_pend;
                if (i_mem_ready) begin
                    imem_ready = 1'b1;
                    state_d    = ST_IDLE;
                    reentry_d  = 1'b1;
                    req_d.ren  = 1'b0;
                    req_d.wen  = 1'b0;
                end
            end
            ST_BUSY_D: begin
                conflict = imem_pend;
                if (i_mem_ready) begin
                    dmem_ready = 1'b1;
                    state_d    = ST_IDLE;
                    reentry_d  = 1'b1;
                    req_d.ren  = 1'b0;
                    req_d.wen  = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                req_d.ren = 1'b0;
                req_d.wen = 1'b0;
            end
        endcase

        cnt_d = (conflict && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            last_d_q  <= 1'b0;
            reentry_q <= 1'b0;
            req_q     <= MEM_REQ_RESET;
            cnt_q     <= 16'h0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            reentry_q <= reentry_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_imem_ready   = imem_ready;
    assign o_dmem_ready   = dmem_ready;
    assign o_imem_rdata   = imem_ready ? i_mem_rdata : 32'h0;
    assign o_dmem_rdata   = dmem_ready ? i_mem_rdata : 32'h0;

    assign o_mem_addr     = {req_q.word_addr, 2'b00};
    assign o_mem_ren      = req_q.ren;
    assign o_mem_wen      = req_q.wen;
    assign o_mem_wdata    = req_q.wdata;
    assign o_mem_mask     = req_q.mask;
    assign o_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        i_rdy;
    logic [31:0] i_rdata;
    logic        dren, dwen;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dmask;
    logic        d_rdy;
    logic [31:0] d_rdata;
    logic [31:0] m_addr_o;
    logic        m_ren_o, m_wen_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_mask_o;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] cnt_o;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_imem_req     (ireq),
        .i_imem_addr    (iaddr),
        .o_imem_ready   (i_rdy),
        .o_imem_rdata   (i_rdata),
        .i_dmem_ren     (dren),
        .i_dmem_wen     (dwen),
        .i_dmem_addr    (daddr),
        .i_dmem_wdata   (dwdata),
        .i_dmem_mask    (dmask),
        .o_dmem_ready   (d_rdy),
        .o_dmem_rdata   (d_rdata),
        .o_mem_addr     (m_addr_o),
        .o_mem_ren      (m_ren_o),
        .o_mem_wen      (m_wen_o),
        .o_mem_wdata    (m_wdata_o),
        .o_mem_mask     (m_mask_o),
        .i_mem_ready    (mem_ready),
        .i_mem_rdata    (mem_rdata),
        .o_conflict_cnt (cnt_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Transaction-level model: who owns memory, what was latched, raw conflict tally
    int          m_owner = 0;        // 0 none, 1 fetch, 2 data
    bit          m_cool  = 0;        // arbiter just finished an access
    int          m_last  = 1;        // last winner
    longint      m_cnt   = 0;
    logic [31:0] m_addr  = 0;
    bit          m_ren   = 0, m_wen = 0;
    logic [31:0] m_wdata = 0;
    logic [3:0]  m_mask  = 0;
    bit          cmp_en  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                bit er_i, er_d, ip, dp;
                int w;
                er_i = (m_owner == 1) && mem_ready;
                er_d = (m_owner == 2) && mem_ready;
                check("imem_ready", i_rdy, er_i);
                check("dmem_ready", d_rdy, er_d);
                check("imem_rdata", i_rdata, er_i ? mem_rdata : 32'h0);
                check("dmem_rdata", d_rdata, er_d ? mem_rdata : 32'h0);
                check("mem_ren", m_ren_o, (m_owner != 0) ? m_ren : 1'b0);
                check("mem_wen", m_wen_o, (m_owner != 0) ? m_wen : 1'b0);
                if (m_owner != 0) begin
                    check("mem_addr", m_addr_o, {m_addr[31:2], 2'b00});
                    check("mem_mask", m_mask_o, m_mask);
                    if (m_wen) check("mem_wdata", m_wdata_o, m_wdata);
                end
                check("conflict_cnt", cnt_o, (m_cnt > 65535) ? 32'hFFFF : 32'(m_cnt));

                ip = ireq;
                dp = dren | dwen;
                if (rst) begin
                    m_owner = 0; m_cool = 0; m_last = 1; m_cnt = 0;
                    m_addr = 0; m_ren = 0; m_wen = 0; m_wdata = 0; m_mask = 0;
                end else if (m_owner == 0) begin
                    if (ip && dp) m_cnt++;
                    if (!m_cool && (ip || dp)) begin
                        w = (ip && dp) ? ((m_last == 1) ? 2 : 1) : (ip ? 1 : 2);
                        m_owner = w;
                        m_last  = w;
                        if (w == 1) begin
                            m_addr = iaddr; m_ren = 1; m_wen = 0; m_mask = 4'hF;
                        end else begin
                            m_addr = daddr; m_wen = dwen; m_ren = !dwen; m_mask = dmask; m_wdata = dwdata;
                        end
                    end
                    m_cool = 0;
                end else begin
                    if ((m_owner == 1) ? dp : ip) m_cnt++;
                    if (mem_ready) begin
                        m_owner = 0;
                        m_cool  = 1;
                    end
                end
            end
        end
    end

    // Memory responder: ready after mem_lat busy cycles
    bit          resp_en    = 1;
    int          mem_lat    = 1;
    logic [31:0] resp_rdata = 32'h0;

    initial begin
        int busy = 0;
        mem_ready = 0;
        mem_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                if (m_ren_o || m_wen_o) begin
                    busy++;
                    if (busy >= mem_lat) begin
                        mem_ready = 1; mem_rdata = resp_rdata;
                    end else begin
                        mem_ready = 0; mem_rdata = 0;
                    end
                end else begin
                    busy = 0; mem_ready = 0; mem_rdata = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        ireq = 0; iaddr = 0; dren = 0; dwen = 0; daddr = 0; dwdata = 0; dmask = 0;
    endtask

    task automatic do_reset();
        step();
        rst = 1;
        clear_reqs();
        step();
        step();
        rst = 0;
    endtask

    task automatic wait_ready(input bit want_d, input string name);
        int n = 0;
        @(negedge clk);
        while (!(want_d ? d_rdy : i_rdy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, want_d ? d_rdy : i_rdy, 1'b1);
    endtask

    initial begin
        int seq_n;
        logic [31:0] seq_bits;
        bit overlap;

        rst = 1;
        clear_reqs();
        step();
        cmp_en = 1;
        step();
        @(negedge clk);
        check("rst_ren", m_ren_o, 0);
        check("rst_wen", m_wen_o, 0);
        check("rst_irdy", i_rdy, 0);
        check("rst_drdy", d_rdy, 0);
        check("rst_addr", m_addr_o, 0);
        check("rst_wdata", m_wdata_o, 0);
        check("rst_mask", m_mask_o, 0);
        check("rst_cnt", cnt_o, 0);
        do_reset();

        // Fetch alone, memory ready two cycles after grant
        mem_lat = 2; resp_rdata = 32'h00000013;
        ireq = 1; iaddr = 32'h100;
        @(negedge clk);
        check("f_grant_ren", m_ren_o, 0);
        @(negedge clk);
        check("f_addr", m_addr_o, 32'h100);
        check("f_ren", m_ren_o, 1);
        check("f_wen", m_wen_o, 0);
        check("f_mask", m_mask_o, 4'hF);
        check("f_early_rdy", i_rdy, 0);
        @(negedge clk);
        check("f_rdy", i_rdy, 1);
        check("f_rdata", i_rdata, 32'h13);
        step();
        ireq = 0;
        @(negedge clk);
        check("f_rdy_once", i_rdy, 0);
        check("f_cnt", cnt_o, 0);

        // Simultaneous fetch and load: data wins the first tie
        do_reset();
        mem_lat = 1; resp_rdata = 32'hCAFE0001;
        ireq = 1; iaddr = 32'h200;
        dren = 1; daddr = 32'h1002; dmask = 4'b1100;
        @(negedge clk);
        check("t_cnt0", cnt_o, 0);
        @(negedge clk);
        check("t_daddr", m_addr_o, 32'h1000);
        check("t_dren", m_ren_o, 1);
        check("t_dmask", m_mask_o, 4'b1100);
        check("t_drdy", d_rdy, 1);
        check("t_cnt1", cnt_o, 1);
        step();
        dren = 0; daddr = 0; dmask = 0;
        @(negedge clk);
        check("t_cnt2", cnt_o, 2);
        wait_ready(0, "t_irdy");
        check("t_iaddr", m_addr_o, 32'h200);
        step();
        ireq = 0;
        @(negedge clk);
        check("t_cnt_end", cnt_o, 2);

        // Continuous contention: grants alternate starting with data
        do_reset();
        mem_lat = 1; resp_rdata = 32'h12345678;
        ireq = 1; iaddr = 32'h300;
        dren = 1; daddr = 32'h4000; dmask = 4'hF;
        seq_n = 0; seq_bits = 0; overlap = 0;
        for (int k = 0; k < 100 && seq_n < 6; k++) begin
            @(negedge clk);
            if (i_rdy && d_rdy) overlap = 1;
            if (d_rdy) begin seq_bits[seq_n] = 1'b1; seq_n++; end
            else if (i_rdy) seq_n++;
        end
        check("alt_count", seq_n, 6);
        check("alt_order", seq_bits, 32'h15);
        check("alt_overlap", overlap, 0);
        step();
        clear_reqs();

        // Store with both ren and wen set becomes a pure write
        do_reset();
        mem_lat = 1;
        dren = 1; dwen = 1; daddr = 32'h2003; dwdata = 32'hAB000000; dmask = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        check("s_wen", m_wen_o, 1);
        check("s_ren", m_ren_o, 0);
        check("s_addr", m_addr_o, 32'h2000);
        check("s_mask", m_mask_o, 4'b1000);
        check("s_wdata", m_wdata_o, 32'hAB000000);
        check("s_rdy", d_rdy, 1);
        step();
        clear_reqs();

        // Reset during a data access, then a stray memory ready
        do_reset();
        resp_en = 0; mem_ready = 0; mem_rdata = 0;
        dren = 1; daddr = 32'h3000; dmask = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("r_busy", m_ren_o, 1);
        step();
        rst = 1;
        clear_reqs();
        step();
        rst = 0;
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("r_drdy", d_rdy, 0);
        check("r_ren", m_ren_o, 0);
        check("r_cnt", cnt_o, 0);
        step();
        mem_ready = 0; mem_rdata = 0;
        @(negedge clk);
        check("r_drdy2", d_rdy, 0);
        resp_en = 1;

        // Conflict counter saturation
        do_reset();
        mem_lat = 1;
        ireq = 1; iaddr = 32'h500;
        dren = 1; daddr = 32'h6000; dmask = 4'hF;
        repeat (65545) @(negedge clk);
        check("sat_cnt", cnt_o, 32'hFFFF);
        step();
        clear_reqs();
        repeat (4) @(negedge clk);
        check("sat_hold", cnt_o, 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
